fetch_unit: RTL and testbench

Instruction fetch and PC sequencer for the 16-bit processor. Fetches one 16-bit instruction word at a time from instruction memory and presents it to the decode stage, which splits it into `opcode` and `function_code`. It consumes the decoder's `Branch`/`Jump` outputs plus the ALU zero flag to choose the next PC. Single-issue and non-pipelined: each instruction is held until execute accepts it.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and PC sequencer for the 16-bit processor.
// Fetches one instruction word at a time and holds it until execute accepts it.
// The next PC comes from the decoder Branch/Jump outputs and the ALU zero flag.
// Optional feature: define FETCH_HALT_EN to stop fetching on opcode 4'b1111.
// Without it, opcode 4'b1111 is sequenced like any other non-branch instruction.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [3:0]  function_code,
   output logic [15:0] pc,
   input  logic        branch,
   input  logic        jump,
   input  logic        alu_zero,
   output logic        halted
);

   localparam logic [3:0] OpBne = 4'b0101;
`ifdef FETCH_HALT_EN
   localparam logic [3:0] OpHalt = 4'b1111;
`endif

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StHold  = 2'd2
`ifdef FETCH_HALT_EN
      ,
      StHalt  = 2'd3
`endif
   } state_e;

   state_e      state_q;
   logic [15:0] pc1;
   logic [15:0] br_offset;
   logic        br_taken;
   logic [15:0] next_pc;

   // Address and decode fields are plain slices of registers.
   assign imem_addr     = pc;
   assign opcode        = instr[15:12];
   assign function_code = instr[3:0];

`ifndef FETCH_HALT_EN
   assign halted = 1'b0;
`endif

   // Next-PC selection for the held instruction: jump beats branch beats pc+1.
   always_comb begin
      pc1       = pc + 16'd1;
      br_offset = {{12{instr[3]}}, instr[3:0]};
      br_taken  = (opcode == OpBne) ? ~alu_zero : alu_zero;
      if (jump) begin
         next_pc = {pc1[15:12], instr[11:0]};
      end else if (branch && br_taken) begin
         next_pc = pc1 + br_offset;
      end else begin
         next_pc = pc1;
      end
   end

   // Sequencer FSM; all handshake outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= 16'h0000;
`ifdef FETCH_HALT_EN
         halted      <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               state_q  <= StFetch;
               imem_req <= 1'b1;
            end
            StFetch: begin
               if (imem_rvalid) begin
                  instr       <= imem_rdata;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state_q     <= StHold;
               end
            end
            StHold: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
                  if (opcode == OpHalt) begin
                     // pc stays on the halt instruction
                     halted  <= 1'b1;
                     state_q <= StHalt;
                  end else begin
                     pc       <= next_pc;
                     imem_req <= 1'b1;
                     state_q  <= StFetch;
                  end
`else
                  pc       <= next_pc;
                  imem_req <= 1'b1;
                  state_q  <= StFetch;
`endif
               end
            end
`ifdef FETCH_HALT_EN
            StHalt: begin
               // only reset leaves this state
               state_q <= StHalt;
            end
`endif
            default: begin
               state_q     <= StIdle;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (RESET_PC = 16'h0010).
// Honours FETCH_HALT_EN the same way as the design.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [3:0]  function_code;
   logic [15:0] pc;
   logic        branch;
   logic        jump;
   logic        alu_zero;
   logic        halted;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   fetch_unit #(
      .RESET_PC(16'h0010)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .opcode       (opcode),
      .function_code(function_code),
      .pc           (pc),
      .branch       (branch),
      .jump         (jump),
      .alu_zero     (alu_zero),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Wait for a request, check its address, answer after wait_cyc cycles.
   task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] data,
                        input int wait_cyc, input string name, output int seen);
      int n;
      bit stable;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      seen = cyc;
      total++;
      if (imem_req !== 1'b1) $display("FAIL %s req: got %b want 1", name, imem_req);
      else passed++;
      total++;
      if (imem_addr !== exp_addr) $display("FAIL %s addr: got %h want %h", name, imem_addr, exp_addr);
      else passed++;
      stable = 1'b1;
      repeat (wait_cyc) begin
         @(negedge clk);
         if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) stable = 1'b0;
      end
      if (wait_cyc > 0) begin
         total++;
         if (!stable) $display("FAIL %s addr_stable: got unstable want stable", name);
         else passed++;
      end
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
      total++;
      if (instr !== data) $display("FAIL %s instr: got %h want %h", name, instr, data);
      else passed++;
      total++;
      if ({instr_valid, imem_req} !== 2'b10)
         $display("FAIL %s valid/req: got %b%b want 10", name, instr_valid, imem_req);
      else passed++;
      total++;
      if (pc !== exp_addr) $display("FAIL %s pc: got %h want %h", name, pc, exp_addr);
      else passed++;
      total++;
      if ({opcode, function_code} !== {data[15:12], data[3:0]})
         $display("FAIL %s fields: got %h%h want %h%h", name, opcode, function_code,
                  data[15:12], data[3:0]);
      else passed++;
   endtask

   // One-cycle handshake with the given decoder/ALU inputs.
   task automatic accept(input logic b, input logic j, input logic z,
                         input logic [15:0] exp_next, input logic exp_req, input string name);
      instr_ready = 1'b1;
      branch      = b;
      jump        = j;
      alu_zero    = z;
      @(negedge clk);
      instr_ready = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      alu_zero    = 1'b0;
      total++;
      if (pc !== exp_next) $display("FAIL %s next_pc: got %h want %h", name, pc, exp_next);
      else passed++;
      total++;
      if (imem_addr !== exp_next) $display("FAIL %s next_addr: got %h want %h", name, imem_addr, exp_next);
      else passed++;
      total++;
      if ({imem_req, instr_valid} !== {exp_req, 1'b0})
         $display("FAIL %s req/valid: got %b%b want %b0", name, imem_req, instr_valid, exp_req);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
      instr_ready = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      alu_zero    = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({imem_req, instr_valid, halted} !== 3'b000)
         $display("FAIL reset_ctl: got %b%b%b want 000", imem_req, instr_valid, halted);
      else passed++;
      total++;
      if (pc !== 16'h0010 || imem_addr !== 16'h0010)
         $display("FAIL reset_pc: got %h/%h want 0010", pc, imem_addr);
      else passed++;
      total++;
      if (instr !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", instr);
      else passed++;
      rst_n = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req);
      else passed++;
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
         $display("FAIL first_req: got %b@%h want 1@0010", imem_req, imem_addr);
      else passed++;
   endtask

   task automatic test_sequential();
      int s0, s1, s2;
      fetch(16'h0010, 16'h1A01, 0, "seq0", s0);
      accept(1'b0, 1'b0, 1'b0, 16'h0011, 1'b1, "seq0");
      fetch(16'h0011, 16'h1A02, 0, "seq1", s1);
      accept(1'b0, 1'b0, 1'b0, 16'h0012, 1'b1, "seq1");
      fetch(16'h0012, 16'h1A03, 0, "seq2", s2);
      accept(1'b0, 1'b0, 1'b0, 16'h0013, 1'b1, "seq2");
      total++;
      if (s1 - s0 != 2 || s2 - s1 != 2)
         $display("FAIL throughput: got %0d,%0d cycles want 2,2", s1 - s0, s2 - s1);
      else passed++;
   endtask

   task automatic test_backpressure();
      int s;
      bit held;
      fetch(16'h0013, 16'h1B03, 3, "wait3", s);
      held = 1'b1;
      for (int i = 0; i < 4; i++) begin
         // a stray rvalid in HOLD must not disturb the held instruction
         imem_rvalid = (i == 1);
         imem_rdata  = 16'hDEAD;
         @(negedge clk);
         if (instr !== 16'h1B03 || pc !== 16'h0013 || instr_valid !== 1'b1 || imem_req !== 1'b0)
            held = 1'b0;
      end
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
      total++;
      if (!held) $display("FAIL stall_hold: got changed instr=%h pc=%h want 1b03/0013", instr, pc);
      else passed++;
      accept(1'b0, 1'b0, 1'b0, 16'h0014, 1'b1, "stall_adv");
   endtask

   task automatic test_branches();
      int s;
      fetch(16'h0014, 16'h2020, 0, "to20a", s);
      accept(1'b0, 1'b1, 1'b0, 16'h0020, 1'b1, "to20a");
      fetch(16'h0020, 16'h400E, 0, "beq", s);
      accept(1'b1, 1'b0, 1'b1, 16'h001F, 1'b1, "beq_taken");
      fetch(16'h001F, 16'h2020, 0, "to20b", s);
      accept(1'b0, 1'b1, 1'b0, 16'h0020, 1'b1, "to20b");
      fetch(16'h0020, 16'h500E, 0, "bne_nt", s);
      accept(1'b1, 1'b0, 1'b1, 16'h0021, 1'b1, "bne_not_taken");
      fetch(16'h0021, 16'h2020, 0, "to20c", s);
      accept(1'b0, 1'b1, 1'b0, 16'h0020, 1'b1, "to20c");
      fetch(16'h0020, 16'h5003, 0, "bne_t", s);
      accept(1'b1, 1'b0, 1'b0, 16'h0024, 1'b1, "bne_taken");
   endtask

   // Walk the PC across 4K regions: jump to xFFF, then fall through to the next region.
   task automatic climb(input logic [15:0] start, input logic [15:0] stop, output logic [15:0] fin);
      logic [15:0] p, p1, tgt;
      int s;
      p = start;
      for (int k = 0; k < 40 && p != stop; k++) begin
         p1 = p + 16'd1;
         if (p[11:0] == 12'hFFF) begin
            fetch(p, 16'h1000, 0, "climb_seq", s);
            accept(1'b0, 1'b0, 1'b0, p1, 1'b1, "climb_seq");
            p = p1;
         end else begin
            tgt = {p1[15:12], 12'hFFF};
            fetch(p, 16'h2FFF, 0, "climb_jmp", s);
            accept(1'b0, 1'b1, 1'b0, tgt, 1'b1, "climb_jmp");
            p = tgt;
         end
      end
      fin = p;
   endtask

   task automatic test_jump_wrap();
      logic [15:0] p;
      int s;
      climb(16'h0024, 16'h5FFF, p);
      total++;
      if (p !== 16'h5FFF) $display("FAIL climb5: got %h want 5fff", p);
      else passed++;
      fetch(16'h5FFF, 16'h2123, 0, "jump_prio", s);
      accept(1'b1, 1'b1, 1'b1, 16'h6123, 1'b1, "jump_prio");
      climb(16'h6123, 16'hFFFF, p);
      total++;
      if (p !== 16'hFFFF) $display("FAIL climbF: got %h want ffff", p);
      else passed++;
      fetch(16'hFFFF, 16'h1111, 0, "wrap", s);
      accept(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "wrap");
   endtask

   task automatic test_reset_mid_fetch();
      total++;
      if (imem_req !== 1'b1) $display("FAIL mid_pre_req: got %b want 1", imem_req);
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0)
         $display("FAIL mid_rst_ctl: got %b%b want 00", imem_req, instr_valid);
      else passed++;
      total++;
      if (pc !== 16'h0010 || instr !== 16'h0000)
         $display("FAIL mid_rst_regs: got %h/%h want 0010/0000", pc, instr);
      else passed++;
      @(negedge clk);
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hBEEF;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
      total++;
      if (instr !== 16'h0000 || instr_valid !== 1'b0)
         $display("FAIL late_rvalid: got %h/%b want 0000/0", instr, instr_valid);
      else passed++;
      total++;
      if (imem_req !== 1'b1 || pc !== 16'h0010)
         $display("FAIL mid_refetch: got %b@%h want 1@0010", imem_req, pc);
      else passed++;
   endtask

   task automatic test_halt();
      int s;
      int reqs;
      fetch(16'h0010, 16'hF000, 0, "halt_instr", s);
`ifdef FETCH_HALT_EN
      accept(1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, "halt");
      total++;
      if (halted !== 1'b1) $display("FAIL halted: got %b want 1", halted);
      else passed++;
      reqs = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req !== 1'b0) reqs++;
      end
      total++;
      if (reqs != 0) $display("FAIL halt_no_req: got %0d req cycles want 0", reqs);
      else passed++;
      total++;
      if (halted !== 1'b1 || pc !== 16'h0010 || instr_valid !== 1'b0)
         $display("FAIL halt_frozen: got %b/%h/%b want 1/0010/0", halted, pc, instr_valid);
      else passed++;
`else
      reqs = 0;
      accept(1'b0, 1'b0, 1'b0, 16'h0011, 1'b1, "halt_off");
      total++;
      if (halted !== 1'b0) $display("FAIL halted_off: got %b want 0", halted);
      else passed++;
      fetch(16'h0011, 16'h1000, 0, "after_f", s);
      accept(1'b0, 1'b0, 1'b0, 16'h0012, 1'b1, "after_f");
      total++;
      if (halted !== 1'b0 || reqs != 0) $display("FAIL halted_off2: got %b want 0", halted);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_branches();
      test_jump_wrap();
      test_reset_mid_fetch();
      test_halt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
